// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: controller state encoding,
// register-address width and a source/destination match helper.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    // A source operand depends on rd only when it is actually read.
    function automatic logic src_hit(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd
    );
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] count_r;

    // Count register; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != ALL_ONES)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stall,
// branch flush, data-memory freeze with watchdog, and stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic              WDOG_EN   = (TIMEOUT != 0);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              mem_timeout_r;
    logic              freeze_s;
    logic              load_use_s;

    // Hazard qualifiers; x0 never creates a dependency.
    always_comb begin
        freeze_s   = 1'b0;
        load_use_s = 1'b0;
        case (state_r)
            RUN:      freeze_s = mem_req && !mem_ready;
            MEM_WAIT: freeze_s = !mem_ready;
            HALT:     freeze_s = 1'b1;
            default:  freeze_s = 1'b1;
        endcase
        if (ex_is_load && (ex_rd != ZERO_REG)) begin
            load_use_s = src_hit(id_rs1_used, id_rs1, ex_rd) ||
                         src_hit(id_rs2_used, id_rs2, ex_rd);
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Priority: freeze holds a pending branch until the release cycle; a branch
    // overrides load-use because the ID instruction is on the wrong path.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (freeze_s) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use_s) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else begin
            pc_stall     = 1'b0;
        end
    end

    // Next state and watchdog count; a ready on the last allowed cycle wins.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s    = RUN;
                end else if (WDOG_EN && (wait_cnt_r == WAIT_LAST)) begin
                    state_nxt_s    = HALT;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            HALT: begin
                state_nxt_s = HALT;
            end
            default: begin
                state_nxt_s = HALT;
            end
        endcase
    end

    // State, watchdog count and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_r || (state_nxt_s == HALT);
        end
    end

    assign mem_timeout = mem_timeout_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_is_load, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic       ex_mem_stall, mem_wb_flush, mem_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    logic [5:0] ctrl;

    int checks = 0;
    int errors = 0;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_flush}
    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_FREEZE = 6'b110011;
    localparam logic [5:0] C_BRANCH = 6'b001100;
    localparam logic [5:0] C_LOADU  = 6'b110100;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .mem_wb_flush    (mem_wb_flush),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_flush};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_is_load = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        tick();
        rst = 1'b0;

        // load-use on rs1: exactly one bubble
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1 chk("loaduse_rs1", 32'(ctrl), 32'(C_LOADU));
        tick();
        idle_inputs();
        #1 chk("loaduse_cleared", 32'(ctrl), 32'(C_IDLE));
        chk("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);

        // x0 never stalls; rs2 match only when used
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        #1 chk("loaduse_x0", 32'(ctrl), 32'(C_IDLE));
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        #1 chk("loaduse_rs2", 32'(ctrl), 32'(C_LOADU));
        id_rs2_used = 1'b0;
        #1 chk("loaduse_rs2_unused", 32'(ctrl), 32'(C_IDLE));
        ex_is_load = 1'b0; id_rs2_used = 1'b1;
        #1 chk("no_load_no_stall", 32'(ctrl), 32'(C_IDLE));
        tick();
        chk("stall_cnt_unchanged", 32'(stall_cnt), 32'd1);

        // branch beats load-use
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b1; ex_branch_taken = 1'b1;
        #1 chk("branch_over_loaduse", 32'(ctrl), 32'(C_BRANCH));
        tick();
        idle_inputs();
        #1 chk("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cnt), 32'd1);

        // 3-cycle miss with a branch waiting in EX
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        #1 chk("miss_c1_run", 32'(ctrl), 32'(C_FREEZE));
        tick();
        chk("miss_c2", 32'(ctrl), 32'(C_FREEZE));
        tick();
        chk("miss_c3", 32'(ctrl), 32'(C_FREEZE));
        tick();
        mem_ready = 1'b1;
        #1 chk("miss_release_branch", 32'(ctrl), 32'(C_BRANCH));
        tick();
        idle_inputs();
        #1 chk("miss_back_in_run", 32'(ctrl), 32'(C_IDLE));
        chk("miss_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("miss_flush_cnt", 32'(flush_cnt), 32'd2);

        // ready arrives on the 4th MEM_WAIT cycle
        mem_req = 1'b1; mem_ready = 1'b0;
        #1 chk("last_run_freeze", 32'(ctrl), 32'(C_FREEZE));
        tick();
        chk("last_w1", 32'(ctrl), 32'(C_FREEZE));
        tick();
        tick();
        tick();
        chk("last_w4_freeze", 32'(ctrl), 32'(C_FREEZE));
        mem_ready = 1'b1;
        #1 chk("last_w4_ready", 32'(ctrl), 32'(C_IDLE));
        tick();
        idle_inputs();
        #1 chk("last_back_in_run", 32'(ctrl), 32'(C_IDLE));
        chk("last_no_timeout", 32'(mem_timeout), 32'd0);
        chk("last_stall_cnt", 32'(stall_cnt), 32'd8);

        // watchdog: no ready for 4 MEM_WAIT cycles -> HALT
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("wdog_w4_no_timeout_yet", 32'(mem_timeout), 32'd0);
        tick();
        chk("wdog_timeout", 32'(mem_timeout), 32'd1);
        mem_req = 1'b0; mem_ready = 1'b1; ex_branch_taken = 1'b1;
        #1 chk("halt_frozen", 32'(ctrl), 32'(C_FREEZE));
        tick();
        chk("halt_still_frozen", 32'(ctrl), 32'(C_FREEZE));
        chk("halt_stall_cnt", 32'(stall_cnt), 32'd14);
        chk("halt_flush_cnt", 32'(flush_cnt), 32'd2);
        idle_inputs();
        #2 rst = 1'b1;
        #1 chk("rst_halt_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_halt_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_halt_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_halt_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();
        rst = 1'b0;

        // stall counter saturates at 15
        ex_is_load = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_rs2_used = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("sat_reach_15", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold_15", 32'(stall_cnt), 32'd15);
        chk("sat_still_stalling", 32'(ctrl), 32'(C_LOADU));
        idle_inputs();

        // reset in the middle of MEM_WAIT
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1 rst = 1'b0;
        mem_req = 1'b0;
        #1 chk("rst_midwait_run", 32'(ctrl), 32'(C_IDLE));
        chk("rst_midwait_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
